match_controller: RTL
=====================

Name: match_controller

Overview:
Sequences one iterated prisoner's-dilemma match between two strategy modules (player A, player B).
- Clears both players before the match.
- Pulses their shared round_start, samples their decisions and routes each player's move back as the other's opponent_last_move.
- Accumulates payoff scores over a fixed number of rounds, then reports done.
- Sits between the top-level game FSM (start/done) and the strategy instances.

Parameters:
NUM_ROUNDS, 10, rounds per match (1..255)
SCORE_W, 12, width of each score accumulator
PAY_T, 5, payoff to a defector whose opponent cooperated
PAY_R, 3, payoff to each player on mutual cooperation
PAY_P, 1, payoff to each player on mutual defection
PAY_S, 0, payoff to a cooperator whose opponent defected

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a match; sampled only in IDLE
player_reset  output  1  synchronous active-high reset to both strategies
round_start  output  1  one-cycle pulse to both strategies
a_decision  input  1  player A move, 1=defect 0=cooperate
b_decision  input  1  player B move, 1=defect 0=cooperate
a_opp_last  output  1  drives A's opponent_last_move (B's last move)
b_opp_last  output  1  drives B's opponent_last_move (A's last move)
score_a  output  SCORE_W  A cumulative score
score_b  output  SCORE_W  B cumulative score
round_count  output  8  completed rounds this match
busy  output  1  high from CLEAR through SCORE of the last round
done  output  1  high in DONE until the next start

Behaviour:
- Reset (async, reset_n=0): state=IDLE. Reset values: player_reset=0, round_start=0, a_opp_last=0, b_opp_last=0, score_a=0, score_b=0, round_count=0, busy=0, done=0. Reset mid-match aborts immediately; no partial results are retained.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: wait for start=1 -> CLEAR.
  - DONE: behaves as IDLE for start; start=1 -> CLEAR.
  - CLEAR (1 cycle):
    - player_reset=1, busy=1, done=0.
    - Clear scores, round_count, a_opp_last and b_opp_last.
    - -> ISSUE.
  - ISSUE (1 cycle): round_start=1 -> WAIT. Players register their decisions on the edge that ends this state.
  - WAIT (1 cycle): decisions settle -> SCORE.
  - SCORE (1 cycle):
    - Sample a_decision and b_decision.
    - Add payoffs: CC R/R, DC T/S, CD S/T, DD P/P (A/B).
    - a_opp_last<=b_decision; b_opp_last<=a_decision.
    - round_count<=round_count+1.
    - If the new count == NUM_ROUNDS -> DONE (busy=0, done=1); else -> ISSUE.
- Round period: 3 cycles.
- Match latency: start -> done = 2 + 3*NUM_ROUNDS cycles.
- start while busy: ignored.
- start in DONE: restarts the match, and done drops in CLEAR.
- Score arithmetic: unsigned, saturating at 2^SCORE_W-1; never wraps.
- opp_last values hold stable from SCORE through the next ISSUE edge. Round 1 presents 0 (cooperate) to both players.
- round_start and player_reset are never asserted in the same cycle.

Optional Feature:
NOISE_EN
- Defined:
  - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset and in CLEAR, advanced once per SCORE.
  - When the LFSR low 3 bits == 3'b000 in SCORE, both opp_last values are written inverted, modelling a misperceived move.
  - Scores always use the true decisions.
  - Adds output noise_flip (1 bit), high in the cycle after a flipped SCORE.
- Undefined: no LFSR and no noise_flip port; opp_last is exact.

Test Plan:
- Reset, then start with A=0 and B=0 constant, NUM_ROUNDS=10 -> done at cycle 32 after start, score_a=score_b=30, round_count=10.
- A=1 and B=0 constant for 10 rounds -> score_a=50, score_b=0. After round 1, b_opp_last=1 and a_opp_last=0.
- A tied to a grudger strategy, B defects only in round 2 -> a_opp_last=1 observed at round 3 ISSUE. A decisions (with the grudger's one-round lag) and the resulting scores match a cycle-accurate model.
- start pulsed during WAIT of round 4 -> ignored, round_count continues 4,5,...; start in DONE -> player_reset pulse, scores return to 0.
- SCORE_W=4, A=1 and B=0 constant -> score_a saturates at 15 and holds.
- reset_n low during round 5 SCORE -> all outputs return to their reset values asynchronously; the next start runs a full match from round 0.

Source files
------------

// File: rtl/match_if.sv
// Controller-to-players bundle; the controller takes the master side.
// noise_flip exists only when NOISE_EN is defined.
interface match_if #(
    parameter int SCORE_W = 12
);
    logic               start;
    logic               player_reset;
    logic               round_start;
    logic               a_decision;
    logic               b_decision;
    logic               a_opp_last;
    logic               b_opp_last;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic [7:0]         round_count;
    logic               busy;
    logic               done;
`ifdef NOISE_EN
    logic               noise_flip;
`endif

    modport master (
        input  start, a_decision, b_decision,
`ifdef NOISE_EN
        output noise_flip,
`endif
        output player_reset, round_start, a_opp_last, b_opp_last,
        output score_a, score_b, round_count, busy, done
    );

    modport slave (
        output start, a_decision, b_decision,
`ifdef NOISE_EN
        input  noise_flip,
`endif
        input  player_reset, round_start, a_opp_last, b_opp_last,
        input  score_a, score_b, round_count, busy, done
    );
endinterface

// File: rtl/match_controller.sv
// Runs one iterated prisoner's-dilemma match: CLEAR, then ISSUE/WAIT/SCORE per round; start->done = 2+3*NUM_ROUNDS cycles.
// start is ignored while busy. Optional misperception noise on opp_last when NOISE_EN is defined.
module match_controller #(
    parameter int NUM_ROUNDS = 10,
    parameter int SCORE_W    = 12,
    parameter int PAY_T      = 5,
    parameter int PAY_R      = 3,
    parameter int PAY_P      = 1,
    parameter int PAY_S      = 0
) (
    input  logic   clk,
    input  logic   reset_n,
    match_if.master m
);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, SCORE, DONE} state_t;

    localparam logic [32:0] MAX_SCORE = (33'd1 << SCORE_W) - 33'd1;
    localparam logic [32:0] P_T = 33'(PAY_T);
    localparam logic [32:0] P_R = 33'(PAY_R);
    localparam logic [32:0] P_P = 33'(PAY_P);
    localparam logic [32:0] P_S = 33'(PAY_S);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_ROUNDS - 1);

    state_t             state;
    logic [SCORE_W-1:0] next_a;
    logic [SCORE_W-1:0] next_b;
    logic               flip;

    function automatic logic [32:0] payoff(input logic me, input logic opp);
        case ({me, opp})
            2'b00:   return P_R;
            2'b10:   return P_T;
            2'b01:   return P_S;
            default: return P_P;
        endcase
    endfunction

    // Widen before adding so the saturation check sees any carry out of SCORE_W.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [32:0] p);
        logic [32:0] sum;
        sum = 33'(s) + p;
        return (sum > MAX_SCORE) ? MAX_SCORE[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        next_a = sat_add(m.score_a, payoff(m.a_decision, m.b_decision));
        next_b = sat_add(m.score_b, payoff(m.b_decision, m.a_decision));
    end

`ifdef NOISE_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign flip    = (lfsr[2:0] == 3'b000);
`else
    assign flip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            m.player_reset <= 1'b0;
            m.round_start  <= 1'b0;
            m.a_opp_last   <= 1'b0;
            m.b_opp_last   <= 1'b0;
            m.score_a      <= '0;
            m.score_b      <= '0;
            m.round_count  <= 8'd0;
            m.busy         <= 1'b0;
            m.done         <= 1'b0;
`ifdef NOISE_EN
            lfsr           <= 8'hA5;
            m.noise_flip   <= 1'b0;
`endif
        end else begin
            m.player_reset <= 1'b0;
            m.round_start  <= 1'b0;
`ifdef NOISE_EN
            m.noise_flip   <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (m.start) begin
                        state          <= CLEAR;
                        m.player_reset <= 1'b1;
                        m.busy         <= 1'b1;
                        m.done         <= 1'b0;
                        m.score_a      <= '0;
                        m.score_b      <= '0;
                        m.round_count  <= 8'd0;
                        m.a_opp_last   <= 1'b0;
                        m.b_opp_last   <= 1'b0;
`ifdef NOISE_EN
                        lfsr           <= 8'hA5;
`endif
                    end
                end
                CLEAR: begin
                    state         <= ISSUE;
                    m.round_start <= 1'b1;
                end
                ISSUE: state <= WAIT;
                WAIT:  state <= SCORE;
                SCORE: begin
                    // Scores use the true moves; only the feedback to players may be flipped.
                    m.score_a     <= next_a;
                    m.score_b     <= next_b;
                    m.a_opp_last  <= m.b_decision ^ flip;
                    m.b_opp_last  <= m.a_decision ^ flip;
                    m.round_count <= m.round_count + 8'd1;
`ifdef NOISE_EN
                    lfsr          <= {lfsr[6:0], lfsr_fb};
                    m.noise_flip  <= flip;
`endif
                    if (m.round_count == LAST_IDX) begin
                        state  <= DONE;
                        m.busy <= 1'b0;
                        m.done <= 1'b1;
                    end else begin
                        state         <= ISSUE;
                        m.round_start <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
